fp_to_sample: RTL and testbench
===============================

FP_TO_SAMPLE -- requirements
Module: fp_to_sample

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  sole clock; all state SHALL change on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request strobe; sampled high in IDLE begins one conversion.
REQ-005 datain  input  32  IEEE-754 single-precision value produced by the float adder stage; captured on the accepting edge.
REQ-006 dataout  output  16  signed two's-complement Q1.15 sample; value = round(datain × 32768) after saturation.
REQ-007 done  output  1  one-cycle pulse marking dataout/sat valid.
REQ-008 busy  output  1  high from the accepting edge until the edge that raises done, inclusive of that edge.
REQ-009 sat  output  1  high with done when the result was clipped or the input was NaN.

Function
REQ-010 The FSM SHALL have states IDLE, SHIFT, ROUND and OUT, with transitions IDLE->SHIFT on start, SHIFT->ROUND, ROUND->OUT, and OUT->IDLE unconditionally.
REQ-011 In IDLE with start=1, the block SHALL latch datain, raise busy and go to SHIFT.
REQ-012 Input fields SHALL be decoded as follows: s=datain[31], e=datain[30:23], m=datain[22:0], mant24={1,m}.
REQ-013 In SHIFT, for 111≤e≤126 the block SHALL form a 17-bit value r = mant24 >> (134−e), which is the magnitude×2 with one guard bit; the shift amount is 8..23.
REQ-014 In ROUND, the block SHALL compute mag = (r+1)>>1, rounding half away from zero, as a 17-bit unsigned value.
REQ-015 Underflow: e<111 (denormals and ±0 included) SHALL yield dataout=0x0000 with sat=0.
REQ-016 NaN: e=255 with m≠0 SHALL yield dataout=0x0000 with sat=1.
REQ-017 Overflow: e≥127 SHALL saturate to 0x7FFF when s=0 and to 0x8000 when s=1, with sat=1; this includes ±Inf.
REQ-018 Exception: exactly −1.0 (0xBF800000) SHALL yield 0x8000 with sat=0.
REQ-019 Rounding overflow: mag=32768 with s=0 SHALL yield 0x7FFF with sat=1; with s=1 it SHALL yield 0x8000 with sat=0.
REQ-020 Otherwise dataout SHALL be mag when s=0 and −mag (two's complement) when s=1; −0 rounding to 0 SHALL give 0x0000.
REQ-021 In OUT, dataout and sat SHALL be registered and done SHALL pulse for exactly one cycle.
REQ-022 done SHALL rise on the 3rd rising edge after the accepting edge; busy SHALL fall on the edge after that.
REQ-023 dataout and sat SHALL hold their values until the next done.
REQ-024 start asserted while busy=1 SHALL be ignored; the request is not queued.
REQ-025 start held high continuously SHALL yield one conversion per 4 cycles, with datain re-sampled at each IDLE.
REQ-026 datain changes after the accepting edge SHALL NOT affect the in-flight result.

Reset
REQ-027 While reset=0, the FSM SHALL be in IDLE with dataout=0x0000, done=0, busy=0, sat=0, and internal registers cleared.
REQ-028 Reset asserted mid-conversion SHALL abort it immediately, with no done pulse for the aborted request.
REQ-029 After reset deasserts, the first edge with start=1 SHALL be accepted normally.

Verification
REQ-030 Basic values and latency: start with 0x3F000000 (0.5) -> dataout=0x4000, sat=0, done on the 3rd edge after acceptance. Also 0xBF800000 -> 0x8000, sat=0.
REQ-031 Saturation and specials: 0x40000000 (2.0) -> 0x7FFF, sat=1. 0xFF800000 (−Inf) -> 0x8000, sat=1. 0x7FC00000 (NaN) -> 0x0000, sat=1. 0x80000000 (−0) -> 0x0000, sat=0.
REQ-032 Rounding edges: 0x37800000 (2^−16) -> 0x0001. 0x37000000 (2^−17) -> 0x0000. 0x3F7FFFFF -> 0x7FFF, sat=1. 0xBF7FFFFF -> 0x8000, sat=0.
REQ-033 Handshake: start=1 with 0x3E800000 (0.25), then start pulses with 0x3F000000 on the next two edges -> a single done with 0x2000 and the extra starts ignored. Holding start=1 continuously -> done every 4 cycles.
REQ-034 Reset mid-operation: assert reset the cycle after acceptance -> all outputs 0 asynchronously, no done. A later start with 0xBE800000 -> 0xE000.

Source files
------------

// File: rtl/fp_to_sample.sv
// Converts an IEEE-754 single-precision value to a Q1.15 sample. It rounds half away from zero and saturates.
// The conversion is a 4-state sequence; done pulses on the 3rd edge after start is accepted.
//
//   state | meaning
//   IDLE  | waiting for start; datain is latched on the accepting edge
//   SHIFT | classify operand, align mantissa to magnitude*2 with a guard bit
//   ROUND | round half away from zero
//   OUT   | register dataout/sat, pulse done on the way back to IDLE
module fp_to_sample (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] datain,
    output logic [15:0] dataout,
    output logic        done,
    output logic        busy,
    output logic        sat
);

    typedef enum logic [1:0] {IDLE, SHIFT, ROUND, OUT} state_t;
    typedef enum logic [2:0] {CL_NORM, CL_ZERO, CL_NAN, CL_OVF, CL_NEG1} cls_t;

    state_t      state_q, state_d;
    cls_t        cls_q, cls_d;
    logic [31:0] data_q, data_d;
    logic [16:0] r_q, r_d;
    logic [16:0] mag_q, mag_d;
    logic [15:0] dataout_q, dataout_d;
    logic        sat_q, sat_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;

    logic        sgn_w;
    logic [7:0]  exp_w;
    logic [22:0] man_w;
    logic [7:0]  shamt_w;
    logic [16:0] r_shift_w;

    assign sgn_w     = data_q[31];
    assign exp_w     = data_q[30:23];
    assign man_w     = data_q[22:0];
    assign shamt_w   = 8'd134 - exp_w;
    // Only meaningful for exponents 111..126, where the shift is 8..23 and the result fits in 17 bits.
    assign r_shift_w = 17'({1'b1, man_w} >> shamt_w);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cls_q     <= CL_NORM;
            data_q    <= 32'd0;
            r_q       <= 17'd0;
            mag_q     <= 17'd0;
            dataout_q <= 16'd0;
            sat_q     <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            data_q    <= data_d;
            r_q       <= r_d;
            mag_q     <= mag_d;
            dataout_q <= dataout_d;
            sat_q     <= sat_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        data_d    = data_q;
        r_d       = r_q;
        mag_d     = mag_q;
        dataout_d = dataout_q;
        sat_d     = sat_q;
        done_d    = 1'b0;
        busy_d    = busy_q;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    data_d  = datain;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                busy_d = 1'b1;
                r_d    = r_shift_w;
                if (exp_w == 8'hFF && man_w != 23'd0)
                    cls_d = CL_NAN;
                else if (exp_w == 8'd127 && man_w == 23'd0 && sgn_w)
                    cls_d = CL_NEG1;
                else if (exp_w >= 8'd127)
                    cls_d = CL_OVF;
                else if (exp_w < 8'd111)
                    cls_d = CL_ZERO;
                else
                    cls_d = CL_NORM;
                state_d = ROUND;
            end
            ROUND: begin
                busy_d  = 1'b1;
                mag_d   = (r_q + 17'd1) >> 1;
                state_d = OUT;
            end
            OUT: begin
                // busy stays high through the done edge and drops one edge later.
                busy_d  = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
                case (cls_q)
                    CL_ZERO: begin
                        dataout_d = 16'h0000;
                        sat_d     = 1'b0;
                    end
                    CL_NAN: begin
                        dataout_d = 16'h0000;
                        sat_d     = 1'b1;
                    end
                    CL_NEG1: begin
                        dataout_d = 16'h8000;
                        sat_d     = 1'b0;
                    end
                    CL_OVF: begin
                        dataout_d = sgn_w ? 16'h8000 : 16'h7FFF;
                        sat_d     = 1'b1;
                    end
                    default: begin
                        if (mag_q[16] || mag_q[15]) begin
                            // Only 32768 can reach here; it is representable only as a negative value.
                            dataout_d = sgn_w ? 16'h8000 : 16'h7FFF;
                            sat_d     = !sgn_w;
                        end else begin
                            dataout_d = sgn_w ? (16'd0 - mag_q[15:0]) : mag_q[15:0];
                            sat_d     = 1'b0;
                        end
                    end
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    assign dataout = dataout_q;
    assign sat     = sat_q;
    assign done    = done_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_fp_to_sample.sv
// Directed bench for fp_to_sample. Expected samples are queued when a request is driven.
// They are checked against dataout/sat and the done timing when done appears.
module tb_fp_to_sample;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] datain;
    logic [15:0] dataout;
    logic        done;
    logic        busy;
    logic        sat;

    typedef struct {
        logic [15:0] d;
        logic        s;
        int          c;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_assert = 0;
    int   n_fail = 0;

    fp_to_sample dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .datain  (datain),
        .dataout (dataout),
        .done    (done),
        .busy    (busy),
        .sat     (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Scoreboard: every done must match the oldest outstanding request.
    always @(posedge clk) begin
        #1;
        if (done === 1'b1) begin
            n_assert++;
            assert (q.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_done observed=%h expected=no_done", dataout);
            end
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                chk("dataout", {16'd0, dataout}, {16'd0, e.d});
                chk("sat", {31'd0, sat}, {31'd0, e.s});
                chk("done_cycle", cyc, e.c);
                chk("busy_at_done", {31'd0, busy}, 32'd1);
            end
        end
    end

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (q.size() != 0 && n < 12) begin
            @(negedge clk);
            n++;
        end
        n_assert++;
        assert (q.size() == 0) else begin
            n_fail++;
            $error("FAIL %s_timeout observed=%0d_pending expected=0_pending", tag, q.size());
        end
        q.delete();
    endtask

    task automatic conv(input logic [31:0] din, input logic [15:0] expd, input logic exps);
        exp_t e;
        @(negedge clk);
        start  = 1'b1;
        datain = din;
        e.d = expd;
        e.s = exps;
        e.c = cyc + 4;
        q.push_back(e);
        @(negedge clk);
        start  = 1'b0;
        datain = $urandom();
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        wait_drain("conv");
        chk("busy_done_cycle", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("busy_fall", {31'd0, busy}, 32'd0);
        chk("dataout_hold", {16'd0, dataout}, {16'd0, expd});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b0;
        start  = 1'b0;
        datain = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_dataout", {16'd0, dataout}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_sat", {31'd0, sat}, 32'd0);
        reset = 1'b1;

        conv(32'h3F000000, 16'h4000, 1'b0);
        conv(32'hBF800000, 16'h8000, 1'b0);
        conv(32'h40000000, 16'h7FFF, 1'b1);
        conv(32'hFF800000, 16'h8000, 1'b1);
        conv(32'h7F800000, 16'h7FFF, 1'b1);
        conv(32'h7FC00000, 16'h0000, 1'b1);
        conv(32'h80000000, 16'h0000, 1'b0);
        conv(32'h37800000, 16'h0001, 1'b0);
        conv(32'hB7800000, 16'hFFFF, 1'b0);
        conv(32'h37000000, 16'h0000, 1'b0);
        conv(32'h00000001, 16'h0000, 1'b0);
        conv(32'h3F7FFFFF, 16'h7FFF, 1'b1);
        conv(32'hBF7FFFFF, 16'h8000, 1'b0);
        conv(32'h3F800000, 16'h7FFF, 1'b1);
        conv(32'h3EAAAAAB, 16'h2AAB, 1'b0);
        conv(32'hBEAAAAAB, 16'hD555, 1'b0);

        // Starts during a conversion are dropped, not queued.
        begin
            exp_t e;
            @(negedge clk);
            start  = 1'b1;
            datain = 32'h3E800000;
            e.d = 16'h2000;
            e.s = 1'b0;
            e.c = cyc + 4;
            q.push_back(e);
            @(negedge clk);
            datain = 32'h3F000000;
            @(negedge clk);
            @(negedge clk);
            start = 1'b0;
            wait_drain("handshake");
            repeat (5) @(negedge clk);
        end

        // Continuous start: one conversion every 4 cycles, in-flight datain changes ignored.
        begin
            logic [31:0] vin[3];
            logic [15:0] vout[3];
            exp_t e;
            vin[0] = 32'h3E800000; vout[0] = 16'h2000;
            vin[1] = 32'hBE800000; vout[1] = 16'hE000;
            vin[2] = 32'h3F000000; vout[2] = 16'h4000;
            @(negedge clk);
            start = 1'b1;
            for (int i = 0; i < 3; i++) begin
                datain = vin[i];
                e.d = vout[i];
                e.s = 1'b0;
                e.c = cyc + 4;
                q.push_back(e);
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    datain = $urandom();
                end
                @(negedge clk);
            end
            start = 1'b0;
            wait_drain("stream");
            repeat (5) @(negedge clk);
        end

        // Reset one cycle after acceptance aborts the conversion.
        conv(32'h40000000, 16'h7FFF, 1'b1);
        @(negedge clk);
        start  = 1'b1;
        datain = 32'h3F000000;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        #1;
        chk("abort_dataout", {16'd0, dataout}, 32'd0);
        chk("abort_sat", {31'd0, sat}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        conv(32'hBE800000, 16'hE000, 1'b0);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
